// File: rtl/axis_rr_arbiter_if.sv
// Handshake bundle between the requesters, the round-robin arbiter and its downstream sink.
// The master modport is the arbiter's view; slave is the environment driving requests and ready.
interface axis_rr_arbiter_if #(
    parameter int N_REQ    = 4,
    parameter int BITWIDTH = 8
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]          s_valid;
    logic [N_REQ-1:0]          s_ready;
    logic [N_REQ*BITWIDTH-1:0] s_data;
    logic                      m_valid;
    logic                      m_ready;
    logic [BITWIDTH-1:0]       m_data;
    logic [ID_W-1:0]           m_id;

    modport master (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_id
    );

    modport slave (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_id
    );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter merging N_REQ stream requesters onto one registered output channel,
// tagging each beat with its source index and capping consecutive beats per grant at BURST.
module axis_rr_arbiter #(
    parameter int N_REQ    = 4,
    parameter int BITWIDTH = 8,
    parameter int BURST    = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    axis_rr_arbiter_if.master   bus,
    output logic [N_REQ-1:0]    grant_o
);
    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     owner_q, owner_d;
    logic [7:0]          beatCnt_q, beatCnt_d;
    logic                mValid_q, mValid_d;
    logic [BITWIDTH-1:0] mData_q, mData_d;
    logic [ID_W-1:0]     mId_q, mId_d;

    logic [BITWIDTH-1:0] lane [N_REQ];
    logic [ID_W-1:0]     pick;
    logic                found;
    logic [ID_W:0]       cand;
    logic [N_REQ-1:0]    readyRaw;
    logic [ID_W-1:0]     ownerNext;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            lane[i] = bus.s_data[i*BITWIDTH +: BITWIDTH];
        end
    end

    // Scan from the farthest offset back to ptr so the closest valid requester wins last.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) begin
                cand = cand - (ID_W+1)'(N_REQ);
            end
            if (bus.s_valid[cand[ID_W-1:0]]) begin
                pick  = cand[ID_W-1:0];
                found = 1'b1;
            end
        end
    end

    assign ownerNext = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        beatCnt_d = beatCnt_q;
        mValid_d  = mValid_q;
        mData_d   = mData_q;
        mId_d     = mId_q;
        readyRaw  = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    readyRaw[pick] = 1'b1;
                    mData_d        = lane[pick];
                    mId_d          = pick;
                    owner_d        = pick;
                    mValid_d       = 1'b1;
                    beatCnt_d      = 8'd1;
                    state_d        = SEND;
                end
            end
            SEND: begin
                if (bus.m_ready) begin
                    if ((beatCnt_q < 8'(BURST)) && bus.s_valid[owner_q]) begin
                        readyRaw[owner_q] = 1'b1;
                        mData_d           = lane[owner_q];
                        mId_d             = owner_q;
                        beatCnt_d         = beatCnt_q + 8'd1;
                    end else begin
                        mValid_d = 1'b0;
                        ptr_d    = ownerNext;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            beatCnt_q <= '0;
            mValid_q  <= 1'b0;
            mData_q   <= '0;
            mId_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            beatCnt_q <= beatCnt_d;
            mValid_q  <= mValid_d;
            mData_q   <= mData_d;
            mId_q     <= mId_d;
        end
    end

    // Ready must not leak a handshake on a reset edge, since that beat would be lost.
    assign bus.s_ready = rst_ni ? readyRaw : '0;
    assign bus.m_valid = mValid_q;
    assign bus.m_data  = mData_q;
    assign bus.m_id    = mId_q;

    always_comb begin
        grant_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_o[i] = (state_q == SEND) && (owner_q == ID_W'(i));
        end
    end
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, all compared each cycle
// against a behavioural arbitration model.
module tb_axis_rr_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int B = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] grant;

    always #5 clk = ~clk;

    axis_rr_arbiter_if #(.N_REQ(N), .BITWIDTH(W)) bus ();

    axis_rr_arbiter #(.N_REQ(N), .BITWIDTH(W), .BURST(B)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .bus     (bus),
        .grant_o (grant)
    );

    int checks   = 0;
    int failures = 0;

    logic         reqValid [N];
    logic [W-1:0] reqData  [N];

    // Reference model: busy means a beat sits in the output register.
    logic         mBusy;
    int           mPtr, mOwner, mBeats, mId;
    logic [W-1:0] mData;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic raise(input int i);
        if (!reqValid[i]) begin
            reqValid[i] = 1'b1;
            reqData[i]  = W'($urandom);
        end
    endtask

    task automatic clearReqs();
        for (int i = 0; i < N; i++) reqValid[i] = 1'b0;
    endtask

    // One clock cycle: drive, predict, check ready, clock, check registered outputs.
    task automatic applyStimulus(input logic mReady, input logic rstLow);
        logic [N-1:0] expReady;
        logic [N-1:0] acc;
        logic [N-1:0] expGrant;
        logic         nBusy;
        int           nPtr, nOwner, nBeats, nId, g;
        logic [W-1:0] nData;
        bit           hit;
        for (int i = 0; i < N; i++) begin
            bus.s_valid[i]         = reqValid[i];
            bus.s_data[i*W +: W]   = reqData[i];
        end
        bus.m_ready = mReady;
        rst_n       = !rstLow;
        #1;
        expReady = '0;
        nBusy = mBusy; nPtr = mPtr; nOwner = mOwner; nBeats = mBeats; nId = mId; nData = mData;
        if (!mBusy) begin
            hit = 0; g = 0;
            for (int k = 0; k < N; k++) begin
                if (!hit && reqValid[(mPtr + k) % N]) begin
                    hit = 1;
                    g   = (mPtr + k) % N;
                end
            end
            if (hit) begin
                expReady[g] = 1'b1;
                nData = reqData[g]; nId = g; nOwner = g; nBeats = 1; nBusy = 1'b1;
            end
        end else if (mReady) begin
            if (mBeats < B && reqValid[mOwner]) begin
                expReady[mOwner] = 1'b1;
                nData = reqData[mOwner]; nId = mOwner; nBeats = mBeats + 1;
            end else begin
                nBusy = 1'b0;
                nPtr  = (mOwner + 1) % N;
            end
        end
        if (rstLow) expReady = '0;
        checkOutput("s_ready", 32'(bus.s_ready), 32'(expReady));
        acc = bus.s_valid & bus.s_ready;
        @(posedge clk);
        if (rstLow) begin
            mBusy = 1'b0; mPtr = 0; mOwner = 0; mBeats = 0; mId = 0; mData = '0;
        end else begin
            mBusy = nBusy; mPtr = nPtr; mOwner = nOwner; mBeats = nBeats; mId = nId; mData = nData;
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i]) reqValid[i] = 1'b0;
        end
        #1;
        expGrant = mBusy ? N'(1 << mOwner) : '0;
        checkOutput("m_valid", 32'(bus.m_valid), 32'(mBusy));
        checkOutput("m_data", 32'(bus.m_data), 32'(mData));
        checkOutput("m_id", 32'(bus.m_id), 32'(mId));
        checkOutput("grant", 32'(grant), 32'(expGrant));
    endtask

    task automatic drain();
        clearReqs();
        for (int c = 0; c < 4 && mBusy; c++) applyStimulus(1'b1, 1'b0);
    endtask

    int burstIds [8] = '{1, 1, -1, 2, 2, -1, 1, 1};

    initial begin
        clearReqs();
        for (int i = 0; i < N; i++) reqData[i] = '0;
        mBusy = 1'b0; mPtr = 0; mOwner = 0; mBeats = 0; mId = 0; mData = '0;
        bus.s_valid = '0; bus.s_data = '0; bus.m_ready = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("reset m_valid", 32'(bus.m_valid), 32'd0);
        checkOutput("reset grant", 32'(grant), 32'd0);

        // Single requester, one beat.
        reqValid[0] = 1'b1; reqData[0] = 8'hA5;
        applyStimulus(1'b1, 1'b0);
        checkOutput("single m_data", 32'(bus.m_data), 32'hA5);
        checkOutput("single grant", 32'(grant), 32'b0001);
        applyStimulus(1'b1, 1'b0);
        checkOutput("single m_valid drop", 32'(bus.m_valid), 32'd0);
        drain();

        // Bursting between requesters 1 and 2.
        for (int c = 0; c < 8; c++) begin
            raise(1); raise(2);
            applyStimulus(1'b1, 1'b0);
            if (burstIds[c] < 0) checkOutput("burst gap", 32'(bus.m_valid), 32'd0);
            else checkOutput("burst id", 32'(bus.m_id), 32'(burstIds[c]));
        end
        drain();

        // Backpressure on a beat from requester 3.
        reqValid[3] = 1'b1; reqData[3] = 8'h3C;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("stall m_data", 32'(bus.m_data), 32'h3C);
            checkOutput("stall m_id", 32'(bus.m_id), 32'd3);
        end
        applyStimulus(1'b1, 1'b0);
        checkOutput("stall release", 32'(bus.m_valid), 32'd0);
        raise(0); raise(3);
        applyStimulus(1'b1, 1'b0);
        checkOutput("ptr after stall", 32'(bus.m_id), 32'd0);
        drain();

        // Reset while a beat from requester 2 is held.
        reqValid[2] = 1'b1; reqData[2] = 8'h77;
        applyStimulus(1'b0, 1'b0);
        checkOutput("pre-reset id", 32'(bus.m_id), 32'd2);
        clearReqs(); raise(0); raise(2);
        applyStimulus(1'b0, 1'b1);
        checkOutput("mid-reset m_valid", 32'(bus.m_valid), 32'd0);
        checkOutput("mid-reset grant", 32'(grant), 32'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("post-reset grant", 32'(bus.m_id), 32'd0);
        drain();

        // Wrap-around: get ptr to 3, then only requester 0 valid.
        reqValid[2] = 1'b1; reqData[2] = 8'h12;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        reqValid[0] = 1'b1; reqData[0] = 8'h5A;
        applyStimulus(1'b1, 1'b0);
        checkOutput("wrap id", 32'(bus.m_id), 32'd0);
        applyStimulus(1'b1, 1'b0);
        raise(0); raise(1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("wrap ptr", 32'(bus.m_id), 32'd1);
        drain();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("idle grant", 32'(grant), 32'd0);
        end

        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1) raise(i);
            end
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Round-robin arbiter that shares one AXI-stream style channel, typically the write side of the `handshake` clock-domain crossing, between `N_REQ` requesters in the same clock domain. Each accepted beat is registered and presented downstream together with the index of its source, so the far side of the crossing can demultiplex it. A configurable burst limit bounds how many consecutive beats one requester may send before the grant rotates.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `BITWIDTH`, default 8: data width per beat.
- `BURST`, default 1: maximum consecutive beats per grant, 1..255.
- `ID_W` (localparam): $clog2(N_REQ).

- `clk`, input, 1: single clock. The block has one clock and a synchronous, active-low reset.
- `rst_n`, input, 1: synchronous reset, active low.
- `s_valid`, input, N_REQ: per-requester valid.
- `s_ready`, output, N_REQ: per-requester ready. At most one bit is high in any cycle.
- `s_data`, input, N_REQ*BITWIDTH: requester i occupies bits [i*BITWIDTH +: BITWIDTH].
- `m_valid`, output, 1: downstream valid (registered).
- `m_ready`, input, 1: downstream ready.
- `m_data`, output, BITWIDTH: downstream data (registered).
- `m_id`, output, ID_W: source index of `m_data` (registered).
- `grant`, output, N_REQ: one-hot owner while in SEND; zero in IDLE.

## Operation
- A beat transfers on a port when valid and ready are both high on the same rising edge (`ok`).
- Internal state:
  - FSM with states IDLE and SEND.
  - `ptr` (ID_W): the highest-priority requester.
  - `owner` (ID_W).
  - `beat_cnt` (8 bits).
- **IDLE:**
  - Select g, the first i with `s_valid[i]=1`, searching from `ptr` upward and wrapping from N_REQ-1 to 0.
  - If such a g exists:
    - Drive `s_ready[g]=1` combinationally.
    - Load `m_data<=s_data[g]`, `m_id<=g`, `owner<=g`, `m_valid<=1`, `beat_cnt<=1`.
    - Go to SEND.
  - If no `s_valid` is set: all `s_ready` are 0 and the FSM stays in IDLE.
- **SEND:** `m_valid=1`. `m_data` and `m_id` are held stable until `m_ready`.
  - `m_ready=0`: all `s_ready` are 0; stay in SEND.
  - `m_ready=1`, `beat_cnt<BURST` and `s_valid[owner]=1`:
    - `s_ready[owner]=1` in the same cycle.
    - Load the new beat, `beat_cnt++`, stay in SEND. This gives back-to-back beats.
  - `m_ready=1` otherwise:
    - `m_valid<=0`, `ptr<=(owner+1) mod N_REQ`, go to IDLE.
    - Arbitration restarts in the following cycle.
- `m_valid` never drops without `m_ready` being seen.
- `grant` = one-hot(`owner`) in SEND, 0 in IDLE.
- `m_ready` while `m_valid=0` is ignored.

## Timing
- Reset values:
  - Outputs: `m_valid=0`, `m_data=0`, `m_id=0`, `grant=0`, `s_ready=0`.
  - Internal: `ptr=0`, `owner=0`, `beat_cnt=0`, FSM in IDLE.
- `rst_n` low overrides everything on that edge, including mid-SEND.
  - A beat held in the output register is discarded.
  - `s_ready` is forced to 0 combinationally while `rst_n=0`.
- Latency: a beat accepted at `s_*` on edge k is valid at `m_*` after edge k, visible in cycle k+1.
- Throughput:
  - Within a burst: 1 beat/cycle.
  - Across a grant change: 1 beat per 2 cycles, because SEND→IDLE→SEND costs one idle cycle.
- No combinational path from `s_*` to `m_*`.
- Combinational paths into `s_ready`: `s_valid`, `ptr`, state and `m_ready`.
- `BURST=1`: every beat returns the FSM to IDLE and rotates `ptr`.
- Burst boundaries:
  - If the owner drops `s_valid` before `BURST` beats, the burst ends on the current downstream transfer.
  - A requester that is not granted keeps `s_valid` and its data asserted (AXI-stream rule). It is served within N_REQ-1 grants.

## Test plan
- **Single requester:** `BURST=1`, `s_valid[0]=1`, `s_data[0]=0xA5` at cycle 0, `m_ready=1`.
  - Cycle 0: `s_ready[0]=1`.
  - Cycle 1: `m_valid=1`, `m_data=0xA5`, `m_id=0`, `grant=4'b0001`.
  - Cycle 2: `m_valid=0`.
- **Fair rotation:** all four requesters valid continuously, `BURST=1`, `m_ready=1`.
  - `m_id` sequence is 0,1,2,3,0,1.
  - One beat every 2 cycles.
  - Each `s_ready` pulse is exactly one cycle wide and never overlaps another.
- **Bursting:** `BURST=2`, requesters 1 and 2 valid, `m_ready=1`.
  - `m_id` is 1,1 on consecutive cycles, one idle cycle, then 2,2, then 1,1.
- **Backpressure:** beat `0x3C` from requester 3, `m_ready=0` for 5 cycles, then 1.
  - `m_valid`, `m_data=0x3C`, `m_id=3` are stable for all 6 cycles.
  - `s_ready=0` throughout the stall.
  - `ptr=0` after the transfer.
- **Reset mid-operation:** `rst_n=0` for one cycle while in SEND with `m_id=2`, then requesters 0 and 2 both valid.
  - The cycle after the reset edge: `m_valid=0`, `grant=0`.
  - The first new grant goes to requester 0.
- **Wrap-around and idle:** `ptr=3`, only requester 0 valid.
  - Requester 0 is granted and `ptr` becomes 1.
  - With no `s_valid`, the block stays in IDLE and all outputs hold their reset-equivalent values.
